// File: rtl/dfe_pkg.sv
// Shared definitions for the DFE chain controller: FSM encoding, widths and defaults.
package dfe_pkg;

    localparam int unsigned DEC_W            = 5;
    localparam int unsigned MAX_DEC_DEF      = 16;
    localparam int unsigned IN_DIV_DEF       = 2;
    localparam int unsigned DRAIN_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StFlush = 2'd3
    } dfe_state_e;

    // A decimation factor is usable when it lies in 1..max_dec.
    function automatic logic dec_legal(input logic [DEC_W-1:0] dec, input int unsigned max_dec);
        return (dec != '0) && (32'(dec) <= max_dec);
    endfunction

endpackage

// File: rtl/dfe_dec_counter.sv
// Counts fd_valid pulses and emits one cic_stb per i_dec pulses.
module dfe_dec_counter
    import dfe_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_fd_valid,
    input  logic [DEC_W-1:0] i_dec,
    output logic             o_cic_stb
);

    logic [DEC_W-1:0] r_cnt;
    logic             r_stb;

    // Count pulses; wrap and strobe on the pulse that completes a group.
    // The >= keeps the counter bounded if the factor shrinks mid-count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_stb <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_stb <= 1'b0;
        end else if (i_fd_valid) begin
            if (r_cnt >= (i_dec - DEC_W'(1))) begin
                r_cnt <= '0;
                r_stb <= 1'b1;
            end else begin
                r_cnt <= r_cnt + DEC_W'(1);
                r_stb <= 1'b0;
            end
        end else begin
            r_stb <= 1'b0;
        end
    end

    assign o_cic_stb = r_stb;

endmodule

// File: rtl/dfe_chain_ctrl.sv
// Control FSM for the DFE chain: run/drain/flush sequencing, input strobe and
// configuration handshake.
module dfe_chain_ctrl
    import dfe_pkg::*;
#(
    parameter int unsigned IN_DIV       = IN_DIV_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned MAX_DEC      = MAX_DEC_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_cfg_wr,
    input  logic [DEC_W-1:0] i_cfg_dec,
    input  logic             i_cfg_filt_en,
    input  logic             i_fd_valid,
    output logic             o_in_stb,
    output logic             o_cic_stb,
    output logic [DEC_W-1:0] o_cic_dec,
    output logic             o_filter_enable,
    output logic             o_flush,
    output logic             o_busy,
    output logic             o_cfg_ack,
    output logic             o_cfg_err
);

    localparam int unsigned PH_W = (IN_DIV > 1) ? $clog2(IN_DIV) : 1;
    localparam int unsigned DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    dfe_state_e       r_state;
    logic [PH_W-1:0]  r_phase;
    logic [DR_W-1:0]  r_drain_cnt;
    logic             r_in_stb;
    logic             r_pend;
    logic [DEC_W-1:0] r_pend_dec;
    logic             r_pend_fen;
    logic [DEC_W-1:0] r_cic_dec;
    logic             r_filt_en;
    logic             r_ack;
    logic             r_err;
    logic             w_legal;

    assign w_legal = dec_legal(i_cfg_dec, MAX_DEC);

    // Sequencing FSM; in_stb is registered so it is high on the first RUN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_phase     <= '0;
            r_drain_cnt <= '0;
            r_in_stb    <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_dec  <= DEC_W'(1);
            r_pend_fen  <= 1'b1;
            r_cic_dec   <= DEC_W'(1);
            r_filt_en   <= 1'b1;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_in_stb <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_cfg_wr) begin
                        if (w_legal) begin
                            r_cic_dec <= i_cfg_dec;
                            r_filt_en <= i_cfg_filt_en;
                            r_ack     <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    // Simultaneous start+stop resolves to stop: stay idle.
                    if (i_start && !i_stop) begin
                        r_state  <= StRun;
                        r_phase  <= '0;
                        r_in_stb <= 1'b1;
                    end
                end
                StRun: begin
                    if (i_stop) begin
                        // A write colliding with stop is discarded.
                        r_err       <= i_cfg_wr;
                        r_state     <= StDrain;
                        r_drain_cnt <= '0;
                        r_phase     <= '0;
                    end else if (i_cfg_wr && w_legal) begin
                        r_pend      <= 1'b1;
                        r_pend_dec  <= i_cfg_dec;
                        r_pend_fen  <= i_cfg_filt_en;
                        r_ack       <= 1'b1;
                        r_state     <= StDrain;
                        r_drain_cnt <= '0;
                        r_phase     <= '0;
                    end else begin
                        r_err <= i_cfg_wr;
                        if (r_phase == PH_W'(IN_DIV - 1)) begin
                            r_phase  <= '0;
                            r_in_stb <= 1'b1;
                        end else begin
                            r_phase <= r_phase + PH_W'(1);
                        end
                    end
                end
                StDrain: begin
                    r_err <= i_cfg_wr;
                    if (r_drain_cnt == DR_W'(DRAIN_CYCLES - 1)) begin
                        r_state <= StFlush;
                        // New configuration is already active while FLUSH is high.
                        if (r_pend) begin
                            r_cic_dec <= r_pend_dec;
                            r_filt_en <= r_pend_fen;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DR_W'(1);
                    end
                end
                StFlush: begin
                    r_err  <= i_cfg_wr;
                    r_pend <= 1'b0;
                    if (r_pend) begin
                        r_state  <= StRun;
                        r_phase  <= '0;
                        r_in_stb <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    dfe_dec_counter u_dec_counter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (o_flush),
        .i_fd_valid (i_fd_valid),
        .i_dec      (r_cic_dec),
        .o_cic_stb  (o_cic_stb)
    );

    assign o_in_stb        = r_in_stb;
    assign o_cic_dec       = r_cic_dec;
    assign o_filter_enable = r_filt_en;
    assign o_flush         = (r_state == StFlush);
    assign o_busy          = (r_state != StIdle);
    assign o_cfg_ack       = r_ack;
    assign o_cfg_err       = r_err;

endmodule
